// File: rtl/fma_pkg.sv
// fma_pkg: shared constants and helpers for the FMA significand datapath.
//   SIG_WIDTH : significand width without hidden bit
//   W         : width of the redundant sum/carry pair from the CSA tree
//   LO / HI   : low/high split of the carry-propagate add
//   LSC_W     : width of the redundant sign-bit count
//   lsc_of()  : redundant sign-bit count of a W-bit two's-complement value
package fma_pkg;

    localparam int SIG_WIDTH = 23;
    localparam int W         = 2 * (SIG_WIDTH + 1) + 3;
    localparam int LO        = 26;
    localparam int HI        = W - LO;
    localparam int LSC_W     = 6;

    // Counts bits below the sign bit that equal the sign bit, stopping at the
    // first one that differs. An all-zero or all-one vector gives W-1.
    function automatic logic [LSC_W-1:0] lsc_of(input logic [W-1:0] vec);
        logic [LSC_W-1:0] cnt;
        logic             stop;
        cnt  = '0;
        stop = 1'b0;
        for (int i = W - 2; i >= 0; i--) begin
            if (!stop) begin
                if (vec[i] == vec[W-1]) begin
                    cnt = cnt + LSC_W'(1);
                end else begin
                    stop = 1'b1;
                end
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/lead_sign_count.sv
// lead_sign_count: combinational redundant sign-bit counter for the normaliser.
//   vec  in  W      two's-complement value
//   lsc  out LSC_W  consecutive bits below the MSB equal to the MSB
//   zero out 1      vec == 0
module lead_sign_count
    import fma_pkg::*;
(
    input  logic [W-1:0]     vec,
    output logic [LSC_W-1:0] lsc,
    output logic             zero
);

    always_comb begin
        lsc  = lsc_of(vec);
        zero = (vec == '0);
    end

endmodule

// File: rtl/sad_resolve_pipe.sv
// sad_resolve_pipe: two-stage carry-propagate resolution of the CSA sum/carry
// pair into a two's-complement result plus redundant sign-bit count.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  upstream handshake for sum/carry
//   sum, carry           W-bit redundant pair (carry already aligned)
//   out_valid/out_ready  downstream handshake
//   result               (sum + carry) mod 2^W
//   lsc, zero            redundant sign-bit count and result == 0
module sad_resolve_pipe
    import fma_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     sum,
    input  logic [W-1:0]     carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     result,
    output logic [LSC_W-1:0] lsc,
    output logic             zero
);

    logic          v1;
    logic          v2;
    logic [LO-1:0] lo_q;
    logic          c26_q;
    logic [HI-1:0] s_hi_q;
    logic [HI-1:0] c_hi_q;

    logic          advance1;
    logic          advance2;
    logic [LO:0]   lo_add;
    logic [HI-1:0] hi_add;
    logic [W-1:0]  res_d;
    logic [LSC_W-1:0] lsc_d;
    logic          zero_d;

    // Stage 2 can take stage 1's pair whenever its own slot is empty or is
    // being emptied this cycle; stage 1 frees up whenever it hands off.
    assign advance2 = v1 & (~v2 | out_ready);
    assign in_ready = ~v1 | advance2;
    assign advance1 = in_valid & in_ready;

    assign lo_add = {1'b0, sum[LO-1:0]} + {1'b0, carry[LO-1:0]};
    assign hi_add = s_hi_q + c_hi_q + HI'(c26_q);
    assign res_d  = {hi_add, lo_q};

    lead_sign_count u_lsc (
        .vec  (res_d),
        .lsc  (lsc_d),
        .zero (zero_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            lo_q   <= '0;
            c26_q  <= 1'b0;
            s_hi_q <= '0;
            c_hi_q <= '0;
        end else begin
            if (advance1) begin
                v1     <= 1'b1;
                lo_q   <= lo_add[LO-1:0];
                c26_q  <= lo_add[LO];
                s_hi_q <= sum[W-1:LO];
                c_hi_q <= carry[W-1:LO];
            end else if (advance2) begin
                v1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2     <= 1'b0;
            result <= '0;
            lsc    <= '0;
            zero   <= 1'b0;
        end else begin
            if (advance2) begin
                v2     <= 1'b1;
                result <= res_d;
                lsc    <= lsc_d;
                zero   <= zero_d;
            end else if (out_ready) begin
                v2 <= 1'b0;
            end
        end
    end

    assign out_valid = v2;

endmodule

// File: tb/tb_sad_resolve_pipe.sv
module tb_sad_resolve_pipe;
    import fma_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     sum;
    logic [W-1:0]     carry;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     result;
    logic [LSC_W-1:0] lsc;
    logic             zero;

    sad_resolve_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .carry     (carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .lsc       (lsc),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]     res;
        logic [LSC_W-1:0] l;
        logic             z;
    } exp_t;

    typedef struct {
        logic [W-1:0]     s;
        logic [W-1:0]     c;
        logic [W-1:0]     res;
        logic [LSC_W-1:0] l;
        logic             z;
    } vec_t;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    logic             last_ov;
    logic             last_ir;
    logic [W-1:0]     last_res;
    logic [LSC_W-1:0] last_lsc;
    logic             last_zero;

    logic             stalled = 1'b0;
    logic [W-1:0]     hold_res;
    logic [LSC_W-1:0] hold_lsc;
    logic             hold_zero;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain modular add, and sign-bit count from the position of
    // the highest bit that differs from the sign.
    function automatic exp_t model(input logic [W-1:0] s, input logic [W-1:0] c);
        exp_t e;
        logic [W:0]   full;
        logic [W-2:0] mag;
        int           top;
        full  = {1'b0, s} + {1'b0, c};
        e.res = full[W-1:0];
        e.z   = (e.res == 0);
        mag   = e.res[W-1] ? ~e.res[W-2:0] : e.res[W-2:0];
        top   = -1;
        for (int i = 0; i < W - 1; i++) if (mag[i]) top = i;
        e.l = (top < 0) ? LSC_W'(W - 1) : LSC_W'(W - 2 - top);
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_w();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[W-1:0];
    endfunction

    // One clock cycle: drive, let outputs settle, score handshakes, advance.
    task automatic run_cycle(input logic iv, input logic [W-1:0] s, input logic [W-1:0] c,
                             input logic ordy);
        exp_t e;
        in_valid  = iv;
        sum       = s;
        carry     = c;
        out_ready = ordy;
        #2;
        last_ov   = out_valid;
        last_ir   = in_ready;
        last_res  = result;
        last_lsc  = lsc;
        last_zero = zero;
        chk("in_ready", in_ready, (sb.size() < 2) || out_ready);
        if (stalled) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_result", result, hold_res);
            chk("stall_lsc", lsc, hold_lsc);
            chk("stall_zero", zero, hold_zero);
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("lsc", lsc, e.l);
                chk("zero", zero, e.z);
            end
        end
        stalled   = out_valid && !out_ready;
        hold_res  = result;
        hold_lsc  = lsc;
        hold_zero = zero;
        if (in_valid && in_ready) sb.push_back(model(s, c));
        @(posedge clk);
        #1;
    endtask

    localparam logic [W-1:0] ONES = {W{1'b1}};
    vec_t vt[6];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vt[0] = '{s: 51'd3,             c: 51'd8, res: 51'd11,         l: 6'd46, z: 1'b0};
        vt[1] = '{s: 51'h3ffffff,       c: 51'd1, res: 51'h4000000,    l: 6'd23, z: 1'b0};
        vt[2] = '{s: ONES,              c: 51'd0, res: ONES,           l: 6'd50, z: 1'b0};
        vt[3] = '{s: ONES,              c: 51'd1, res: 51'd0,          l: 6'd50, z: 1'b1};
        vt[4] = '{s: 51'h4000000000000, c: 51'd0, res: 51'h4000000000000, l: 6'd0, z: 1'b0};
        vt[5] = '{s: ONES,              c: ONES - 51'd1, res: ONES - 51'd2, l: 6'd48, z: 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; sum = '0; carry = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_result", result, 51'd0);
        chk("rst_lsc", lsc, 6'd0);
        chk("rst_zero", zero, 1'b0);
        rst_n = 1'b1;

        // Directed vectors: presented cycle k, valid two edges later.
        for (int i = 0; i < 6; i++) begin
            run_cycle(1'b1, vt[i].s, vt[i].c, 1'b1);
            run_cycle(1'b0, '0, '0, 1'b1);
            chk("vec_early_valid", last_ov, 1'b0);
            run_cycle(1'b0, '0, '0, 1'b1);
            chk("vec_valid", last_ov, 1'b1);
            chk("vec_result", last_res, vt[i].res);
            chk("vec_lsc", last_lsc, vt[i].l);
            chk("vec_zero", last_zero, vt[i].z);
        end

        // Backpressure: 5 pairs streamed, out_ready low for cycles 3..6.
        begin
            int sent = 0;
            int low_seen = 0;
            logic [W-1:0] bs, bc;
            for (int cyc = 0; cyc < 16; cyc++) begin
                bs = rnd_w();
                bc = rnd_w() & ~51'd1;
                run_cycle(sent < 5, bs, bc, !(cyc >= 3 && cyc <= 6));
                if (!last_ir) low_seen++;
                if (sent < 5 && last_ir) sent++;
            end
            chk("bp_in_ready_low_seen", low_seen > 0, 1'b1);
            chk("bp_all_delivered", sb.size(), 0);
        end

        // Full throughput: 100 back-to-back pairs.
        for (int k = 0; k < 102; k++) begin
            run_cycle(k < 100, rnd_w(), rnd_w() & ~51'd1, 1'b1);
            chk("thru_valid", last_ov, (k >= 2) && (k < 102));
        end
        chk("thru_drained", sb.size(), 0);

        // Random handshakes on both sides.
        for (int k = 0; k < 300; k++)
            run_cycle($urandom_range(0, 1), rnd_w(), rnd_w() & ~51'd1, $urandom_range(0, 3) != 0);
        for (int k = 0; k < 20 && sb.size() > 0; k++)
            run_cycle(1'b0, '0, '0, 1'b1);
        chk("rand_drained", sb.size(), 0);

        // Reset with both stages full.
        run_cycle(1'b1, rnd_w(), 51'd2, 1'b0);
        run_cycle(1'b1, rnd_w(), 51'd4, 1'b0);
        run_cycle(1'b1, rnd_w(), 51'd6, 1'b0);
        chk("full_in_ready", last_ir, 1'b0);
        chk("full_out_valid", last_ov, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 1'b0);
        chk("async_in_ready", in_ready, 1'b1);
        chk("async_result", result, 51'd0);
        chk("async_lsc", lsc, 6'd0);
        sb.delete();
        stalled = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_cycle(1'b1, 51'd100, 51'd28, 1'b1);
        run_cycle(1'b0, '0, '0, 1'b1);
        chk("post_rst_no_stale", last_ov, 1'b0);
        run_cycle(1'b0, '0, '0, 1'b1);
        chk("post_rst_valid", last_ov, 1'b1);
        chk("post_rst_result", last_res, 51'd128);
        chk("post_rst_lsc", last_lsc, 6'd42);
        run_cycle(1'b0, '0, '0, 1'b1);
        chk("post_rst_single", last_ov, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
